// File: rtl/baud_pkg.sv
// Shared defaults for the fractional baud generator.
package baud_pkg;

  localparam int unsigned DEF_DIV_INT_W  = 16;
  localparam int unsigned DEF_DIV_FRAC_W = 4;
  localparam int unsigned DEF_OVERSAMPLE = 16;
  localparam int unsigned DEF_DIV_INT    = 162;
  localparam int unsigned DEF_DIV_FRAC   = 12;

  function automatic int unsigned os_phase_w(input int unsigned os);
    return (os < 2) ? 1 : $clog2(os);
  endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional accumulator: picks the length of the next oversample period.
module baud_frac_acc
  import baud_pkg::*;
#(
  parameter int unsigned DIV_INT_W  = DEF_DIV_INT_W,
  parameter int unsigned DIV_FRAC_W = DEF_DIV_FRAC_W,
  parameter int unsigned RST_LIMIT  = DEF_DIV_INT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wrap,
  input  logic                  clear,
  input  logic [DIV_INT_W-1:0]  active_int,
  input  logic [DIV_FRAC_W-1:0] active_frac,
  input  logic [DIV_INT_W-1:0]  clear_int,
  output logic [DIV_INT_W:0]    limit
);

  localparam int unsigned LIM_W = DIV_INT_W + 1;

  logic [DIV_FRAC_W-1:0] acc_q, acc_d;
  logic [LIM_W-1:0]      limit_q, limit_d;
  logic [DIV_FRAC_W:0]   sum;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, active_frac};
    acc_d   = acc_q;
    limit_d = limit_q;
    if (clear) begin
      acc_d   = '0;
      limit_d = {1'b0, clear_int};
    end else if (wrap) begin
      acc_d   = sum[DIV_FRAC_W-1:0];
      limit_d = {1'b0, active_int} + {{DIV_INT_W{1'b0}}, sum[DIV_FRAC_W]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      limit_q <= LIM_W'(RST_LIMIT);
    end else begin
      acc_q   <= acc_d;
      limit_q <= limit_d;
    end
  end

  assign limit = limit_q;

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-divisor oversample/bit tick generator with deferred divisor update.
module baud_gen_frac #(
  parameter int unsigned DIV_INT_W    = baud_pkg::DEF_DIV_INT_W,
  parameter int unsigned DIV_FRAC_W   = baud_pkg::DEF_DIV_FRAC_W,
  parameter int unsigned OVERSAMPLE   = baud_pkg::DEF_OVERSAMPLE,
  parameter int unsigned DEF_DIV_INT  = baud_pkg::DEF_DIV_INT,
  parameter int unsigned DEF_DIV_FRAC = baud_pkg::DEF_DIV_FRAC
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       enable,
  input  logic [DIV_INT_W-1:0]                       div_int,
  input  logic [DIV_FRAC_W-1:0]                      div_frac,
  input  logic                                       div_load,
  output logic                                       div_busy,
  output logic                                       cfg_err,
  output logic                                       os_tick,
  output logic                                       bit_tick,
  output logic [baud_pkg::os_phase_w(OVERSAMPLE)-1:0] os_phase
);

  import baud_pkg::*;

  localparam int unsigned        PHASE_W    = os_phase_w(OVERSAMPLE);
  localparam int unsigned        LIM_W      = DIV_INT_W + 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(OVERSAMPLE - 1);

  logic [LIM_W-1:0]      count_q, count_d, limit;
  logic [PHASE_W-1:0]    os_phase_q, os_phase_d;
  logic                  os_tick_q, os_tick_d;
  logic                  bit_tick_q, bit_tick_d;
  logic                  busy_q, busy_d;
  logic                  cfg_err_q, cfg_err_d;
  logic [DIV_INT_W-1:0]  act_int_q, act_int_d, pend_int_q, pend_int_d;
  logic [DIV_FRAC_W-1:0] act_frac_q, act_frac_d, pend_frac_q, pend_frac_d;
  logic                  apply, wrap;

  // The apply edge restarts the period, so it never counts as a wrap.
  assign apply = busy_q && (bit_tick_q || !enable);
  assign wrap  = enable && !apply && (count_q == limit - LIM_W'(1));

  always_comb begin
    count_d     = count_q;
    os_phase_d  = os_phase_q;
    os_tick_d   = 1'b0;
    bit_tick_d  = 1'b0;
    busy_d      = busy_q;
    cfg_err_d   = 1'b0;
    act_int_d   = act_int_q;
    act_frac_d  = act_frac_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;

    if (apply) begin
      count_d    = '0;
      os_phase_d = '0;
      act_int_d  = pend_int_q;
      act_frac_d = pend_frac_q;
      busy_d     = 1'b0;
    end else if (enable) begin
      if (wrap) begin
        count_d    = '0;
        os_tick_d  = 1'b1;
        bit_tick_d = (os_phase_q == PHASE_LAST);
        os_phase_d = (os_phase_q == PHASE_LAST) ? '0 : os_phase_q + PHASE_W'(1);
      end else begin
        count_d = count_q + LIM_W'(1);
      end
    end

    // A request landing on the apply edge becomes the next pending value.
    if (div_load) begin
      if (div_int >= DIV_INT_W'(2)) begin
        pend_int_d  = div_int;
        pend_frac_d = div_frac;
        busy_d      = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      os_phase_q  <= '0;
      os_tick_q   <= 1'b0;
      bit_tick_q  <= 1'b0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      act_int_q   <= DIV_INT_W'(DEF_DIV_INT);
      act_frac_q  <= DIV_FRAC_W'(DEF_DIV_FRAC);
      pend_int_q  <= '0;
      pend_frac_q <= '0;
    end else begin
      count_q     <= count_d;
      os_phase_q  <= os_phase_d;
      os_tick_q   <= os_tick_d;
      bit_tick_q  <= bit_tick_d;
      busy_q      <= busy_d;
      cfg_err_q   <= cfg_err_d;
      act_int_q   <= act_int_d;
      act_frac_q  <= act_frac_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
    end
  end

  baud_frac_acc #(
    .DIV_INT_W (DIV_INT_W),
    .DIV_FRAC_W(DIV_FRAC_W),
    .RST_LIMIT (DEF_DIV_INT)
  ) u_frac_acc (
    .clk        (clk),
    .reset      (reset),
    .wrap       (wrap),
    .clear      (apply),
    .active_int (act_int_q),
    .active_frac(act_frac_q),
    .clear_int  (pend_int_q),
    .limit      (limit)
  );

  assign div_busy = busy_q;
  assign cfg_err  = cfg_err_q;
  assign os_tick  = os_tick_q;
  assign bit_tick = bit_tick_q;
  assign os_phase = os_phase_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: tick-schedule reference model plus directed scenarios.
module tb_baud_gen_frac;

  localparam int unsigned IW  = 16;
  localparam int unsigned FW  = 4;
  localparam int unsigned OS  = 4;
  localparam int unsigned DI  = 13;
  localparam int unsigned DF  = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [IW-1:0] div_int = '0;
  logic [FW-1:0] div_frac = '0;
  logic          div_load = 1'b0;
  logic          div_busy, cfg_err, os_tick, bit_tick;
  logic [1:0]    os_phase;

  baud_gen_frac #(
    .DIV_INT_W   (IW),
    .DIV_FRAC_W  (FW),
    .OVERSAMPLE  (OS),
    .DEF_DIV_INT (DI),
    .DEF_DIV_FRAC(DF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .div_int (div_int),
    .div_frac(div_frac),
    .div_load(div_load),
    .div_busy(div_busy),
    .cfg_err (cfg_err),
    .os_tick (os_tick),
    .bit_tick(bit_tick),
    .os_phase(os_phase)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_tick = 0;
  int last_ivl = 0;

  // Reference: within an epoch (since reset or apply) tick k lands on enabled
  // edge k*I + floor((k-1)*F/2^FW).
  longint m_e;
  longint m_k;
  int     m_int, m_frac, m_pint, m_pfrac;
  bit     m_pv, m_os, m_bt, m_busy, m_err;
  int     m_phase;

  function automatic longint tick_at(input longint k, input int i, input int f);
    return k * i + (((k - 1) * f) >> FW);
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    bit ap;
    if (reset) begin
      m_int = DI; m_frac = DF; m_pv = 0; m_e = 0; m_k = 0;
      m_os = 0; m_bt = 0; m_busy = 0; m_err = 0; m_phase = 0;
    end else begin
      ap   = m_pv && (m_bt || !enable);
      m_os = 0; m_bt = 0; m_err = 0;
      if (ap) begin
        m_int = m_pint; m_frac = m_pfrac; m_pv = 0; m_e = 0; m_k = 0;
      end else if (enable) begin
        m_e++;
        if (m_e == tick_at(m_k + 1, m_int, m_frac)) begin
          m_k++;
          m_os = 1;
          m_bt = (m_k % OS) == 0;
        end
      end
      if (div_load) begin
        if (div_int >= 2) begin
          m_pv = 1; m_pint = int'(div_int); m_pfrac = int'(div_frac);
        end else begin
          m_err = 1;
        end
      end
      m_phase = int'(m_k % OS);
      m_busy  = m_pv;
    end
  endtask

  task automatic step(input bit en, input bit ld, input int di, input int df, input bit rst);
    enable = en; div_load = ld; div_int = IW'(di); div_frac = FW'(df); reset = rst;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk_eq("os_tick", os_tick, m_os);
    chk_eq("bit_tick", bit_tick, m_bt);
    chk_eq("os_phase", os_phase, m_phase);
    chk_eq("div_busy", div_busy, m_busy);
    chk_eq("cfg_err", cfg_err, m_err);
    if (os_tick) begin
      last_ivl  = cyc - last_tick;
      last_tick = cyc;
    end
  endtask

  task automatic run_to_tick(input string tag);
    int n = 0;
    do begin
      step(1, 0, 0, 0, 0);
      n++;
    end while (!os_tick && n < 300);
    chk_eq({tag, "_tick_seen"}, os_tick, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (div_busy && n < 300) begin
      step(1, 0, 0, 0, 0);
      n++;
    end
    chk_eq({tag, "_applied"}, div_busy, 0);
  endtask

  initial begin
    int t4, sum, rcyc, n;
    t4 = 0;

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    chk_eq("rst_phase", os_phase, 0);

    // integer mode 4/0
    step(1, 1, 4, 0, 0);
    chk_eq("int_busy", div_busy, 1);
    wait_idle("int");
    chk_eq("int_phase0", os_phase, 0);
    for (int i = 1; i <= 8; i++) begin
      run_to_tick("int");
      chk_eq("int_phase", os_phase, i % 4);
      chk_eq("int_bit", bit_tick, (i % 4) == 0);
      if (i > 1) chk_eq("int_ivl", last_ivl, 4);
      if (i == 4) t4 = cyc;
      if (i == 8) chk_eq("int_bit_ivl", cyc - t4, 16);
    end

    // fractional mode 10 + 8/16
    step(1, 1, 10, 8, 0);
    wait_idle("frac");
    sum = 0;
    for (int i = 1; i <= 9; i++) begin
      run_to_tick("frac");
      if (i > 1) begin
        chk_eq("frac_ivl", last_ivl, (i % 2 == 0) ? 10 : 11);
        sum += last_ivl;
      end
    end
    chk_eq("frac_sum8", sum, 84);

    // deferred load mid-bit
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(1, 1, 6, 0, 0);
    chk_eq("defer_busy", div_busy, 1);
    wait_idle("defer");
    chk_eq("defer_phase0", os_phase, 0);
    for (int i = 1; i <= 5; i++) begin
      run_to_tick("defer");
      if (i > 1) chk_eq("defer_ivl", last_ivl, 6);
    end

    // rejected requests
    step(1, 1, 1, 5, 0);
    chk_eq("rej1_err", cfg_err, 1);
    chk_eq("rej1_busy", div_busy, 0);
    step(1, 0, 0, 0, 0);
    chk_eq("rej_err_clr", cfg_err, 0);
    step(1, 1, 0, 0, 0);
    chk_eq("rej0_err", cfg_err, 1);
    for (int i = 0; i < 3; i++) begin
      run_to_tick("rej");
      chk_eq("rej_ivl", last_ivl, 6);
    end

    // enable low for 7 cycles mid-period
    run_to_tick("en");
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0);
    run_to_tick("en");
    chk_eq("en_ivl", last_ivl, 13);

    // reset mid-period
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    chk_eq("mrst_tick", os_tick, 0);
    chk_eq("mrst_phase", os_phase, 0);
    rcyc = cyc;
    run_to_tick("mrst");
    chk_eq("mrst_first", cyc - rcyc, DI);

    // load colliding with apply
    step(1, 1, 5, 0, 0);
    n = 0;
    do begin
      step(1, 0, 0, 0, 0);
      n++;
    end while (!bit_tick && n < 300);
    chk_eq("col_bit_seen", bit_tick, 1);
    step(1, 1, 7, 3, 0);
    chk_eq("col_busy", div_busy, 1);
    run_to_tick("col");
    run_to_tick("col");
    chk_eq("col_ivl", last_ivl, 5);
    wait_idle("col");

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
           int'($urandom_range(0, 12)), int'($urandom_range(0, 15)),
           $urandom_range(0, 499) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 SHALL have parameter DIV_INT_W, 16, width of the integer divisor.
REQ-002 SHALL have parameter DIV_FRAC_W, 4, width of the fractional divisor in 1/2^DIV_FRAC_W units.
REQ-003 SHALL have parameter OVERSAMPLE, 16, oversample ticks per bit (>=2).
REQ-004 SHALL have parameter DEF_DIV_INT, 162, integer divisor after reset (50 MHz, x16, 19200 baud).
REQ-005 SHALL have parameter DEF_DIV_FRAC, 12, fractional divisor after reset.
REQ-006 SHALL have port clk  in  1  single clock, rising edge.
REQ-007 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-008 SHALL have port enable  in  1  run when high, hold state when low.
REQ-009 SHALL have port div_int  in  DIV_INT_W  requested integer divisor.
REQ-010 SHALL have port div_frac  in  DIV_FRAC_W  requested fractional divisor.
REQ-011 SHALL have port div_load  in  1  one-cycle request to capture div_int/div_frac.
REQ-012 SHALL have port div_busy  out  1  captured divisor pending, not yet applied.
REQ-013 SHALL have port cfg_err  out  1  one-cycle pulse when a request is rejected.
REQ-014 SHALL have port os_tick  out  1  one-cycle oversample tick.
REQ-015 SHALL have port bit_tick  out  1  one-cycle tick per bit period.
REQ-016 SHALL have port os_phase  out  $clog2(OVERSAMPLE)  os_tick index within the current bit.

Function
REQ-017 SHALL count enabled clk edges; on the edge where the count equals limit-1, count <= 0 and os_tick <= 1, otherwise os_tick <= 0.
REQ-018 SHALL register os_tick, bit_tick and os_phase, so that consecutive os_tick pulses are exactly limit cycles apart.
REQ-019 SHALL, at each os_tick wrap, form sum = acc + active_frac (DIV_FRAC_W+1 bits), set acc <= sum[DIV_FRAC_W-1:0] and next limit = active_int + sum[DIV_FRAC_W].
REQ-020 SHALL use limit = active_int for the first period after reset or after a divisor apply (acc = 0).
REQ-021 SHALL increment os_phase modulo OVERSAMPLE with each os_tick, and assert bit_tick in the same cycle as the os_tick that sets os_phase to 0.
REQ-022 SHALL, while enable is low, hold count, acc and os_phase, and drive os_tick = bit_tick = 0.
REQ-023 SHALL, on div_load with div_int >= 2, capture the pair as pending and set div_busy in the next cycle.
REQ-024 SHALL, on div_load with div_int < 2, pulse cfg_err for one cycle, ignore the request and leave the pending value unchanged.
REQ-025 SHALL apply the pending divisor on the cycle after the edge that produces a bit_tick, or on the next edge if enable is low; the apply clears acc, count and os_phase, and clears div_busy.
REQ-026 SHALL let a new div_load while div_busy is set overwrite the pending value (last request wins).
REQ-027 SHALL, when div_load coincides with an apply, apply the previously pending value and keep the new request pending.
REQ-028 SHALL perform every counter and accumulator operation unsigned and wrap-free, with the count width DIV_INT_W+1 so that limit = 2^DIV_INT_W - 1 + 1 fits.

Reset
REQ-029 SHALL, on reset, set count = 0, acc = 0, os_phase = 0, os_tick = 0, bit_tick = 0, div_busy = 0, cfg_err = 0, active divisor = DEF_DIV_INT/DEF_DIV_FRAC, and discard any pending divisor.
REQ-030 SHALL let reset take priority over enable, div_load and any apply in the same cycle.

Structure
REQ-031 SHALL place DEF_DIV_INT, DEF_DIV_FRAC, the default widths and an oversample-width constant function in shared package baud_pkg.
REQ-032 SHALL implement the fractional accumulator and limit selection (REQ-019/020) as sub-module baud_frac_acc.

Verification
REQ-033 SHALL cover integer mode: DIV_INT=4, frac=0, OVERSAMPLE=4 -> os_tick every 4 cycles, bit_tick every 16 cycles, os_phase 1,2,3,0.
REQ-034 SHALL cover fractional mode: div_int=10, div_frac=8 (DIV_FRAC_W=4) -> os_tick intervals 10,10,11,10,11,... with a mean of 10.5.
REQ-035 SHALL cover deferred load: div_load(6,0) mid-bit -> div_busy=1 until the next bit_tick, then the intervals become 6 and os_phase restarts at 0.
REQ-036 SHALL cover rejection: div_load with div_int=1 -> one-cycle cfg_err and unchanged intervals; div_load with div_int=0 behaves the same.
REQ-037 SHALL cover enable and reset: enable low for 7 cycles mid-period -> no ticks and the period resumes the remaining count; reset mid-period -> all outputs 0 and the next period = DEF_DIV_INT.
REQ-038 SHALL cover collision: a div_load on the apply cycle -> the old pending value is applied and div_busy stays 1 with the new value.
